prefetch_byte_queue: RTL and testbench
======================================

Name: prefetch_byte_queue

Overview:
- Parametrised circular byte queue between the instruction fetch path and the prime decoder.
- Fetch pushes one opcode/operand byte per cycle.
- Decoder sees a combinational peek window of the oldest three bytes and retires a whole instruction (1–3 bytes) in one cycle.
- Flush discards all contents on branch taken or interrupt.

Parameters:
DATA_W, 8, width of one queue entry in bits
DEPTH, 16, number of entries; power of two, minimum 4
PTR_W, 4, pointer width, equal to log2(DEPTH)

Ports:
queue_clk  input  1  single clock, rising edge
queue_reset_n  input  1  asynchronous active-low reset
queue_flush  input  1  synchronous discard of all contents
queue_in  input  DATA_W  byte to enqueue
queue_push  input  1  enqueue request for queue_in
queue_pull_len  input  2  bytes to retire this cycle (0 = none, 1..3)
queue_out  output  3*DATA_W  peek window: [DATA_W-1:0] = oldest byte, then next, then third
queue_valid  output  3  thermometer; bit i set when window slot i holds a valid byte
queue_count  output  PTR_W+1  occupancy, 0..DEPTH
queue_full  output  1  queue_count == DEPTH
queue_push_drop  output  1  one-cycle pulse: push rejected
queue_pull_err  output  1  one-cycle pulse: pull_len > queue_count, pull ignored

Behaviour:
- Storage: DEPTH x DATA_W registers.
- Pointers: ptr_s (read) and ptr_e (write), each PTR_W bits, wrap modulo DEPTH.
- Occupancy: separate count register of PTR_W+1 bits disambiguates full from empty.
- Reset (async, queue_reset_n low):
  - ptr_s = ptr_e = 0, count = 0.
  - queue_valid = 0, queue_full = 0, queue_push_drop = 0, queue_pull_err = 0.
  - Storage contents are not reset.
- Combinational outputs:
  - queue_out slot i = mem[ptr_s+i mod DEPTH].
  - queue_valid[i] = (count > i).
  - Slots with a clear valid bit are don't-care.
- Per-cycle priority: flush > pull > push.
- Flush:
  - ptr_s = ptr_e = 0, count = 0.
  - A push or pull in the same cycle is discarded; neither error pulse fires.
- Pull legality: legal when pull_len <= count.
  - Legal pull: ptr_s += pull_len (mod DEPTH).
  - Illegal pull: pointers unchanged, queue_pull_err pulses next cycle.
- Push acceptance, evaluated against the same-cycle legal pull: accepted when count - legal_pull_len < DEPTH.
  - This lets a full queue accept a push if at least one byte is retired in the same cycle.
  - Accepted push: mem[ptr_e] = queue_in, ptr_e += 1 (mod DEPTH).
  - Rejected push: queue_push_drop pulses next cycle; storage unchanged.
- Count update: count_next = count - legal_pull_len + push_accepted.
  - Computed at PTR_W+1 bits; never underflows or exceeds DEPTH.
- Latency:
  - A pushed byte is visible in the window the cycle after the push edge.
  - A pull takes effect at the edge; the window shows the new head the following cycle.
- Push into an empty queue with pull_len = 1 in the same cycle is illegal (count = 0): the pull is rejected and the push is accepted.
- Error pulses are registered and last exactly one cycle; they never block later operations.
- Reset mid-operation: all state returns to the reset values immediately, with no clock required.

Test Plan:
- Reset, push 0xA9, 0x05, 0x8D in consecutive cycles → count = 3, queue_valid = 3'b111, queue_out = {0x8D, 0x05, 0xA9}.
- From that state, pull_len = 2 → next cycle count = 1, slot0 = 0x8D, queue_valid = 3'b001.
- Push 16 bytes 0x00..0x0F → queue_full = 1; 17th push with pull_len = 0 → queue_push_drop pulses once, count stays 16.
- With the queue full, push 0x10 and pull_len = 1 in the same cycle → count stays 16, slot0 = 0x01, no drop.
- Push 0x20..0x33 with interleaved pulls so ptr_s and ptr_e wrap past 15 → FIFO order preserved and count correct at every cycle.
- count = 1, pull_len = 3 → queue_pull_err pulses, count unchanged.
- count = 5, assert flush together with push and pull → next cycle count = 0, queue_valid = 0, no error pulses.
- Deassert queue_reset_n between clock edges while count = 7 → count = 0 and queue_full = 0 immediately.

Source files
------------

// File: rtl/prefetch_byte_queue.sv
// Circular byte queue between instruction fetch and the decoder: one-byte push per
// cycle, three-byte combinational peek window, whole-instruction (1..3 byte) retire.
module prefetch_byte_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic                queue_clk,
    input  logic                queue_reset_n,
    input  logic                queue_flush,
    input  logic [DATA_W-1:0]   queue_in,
    input  logic                queue_push,
    input  logic [1:0]          queue_pull_len,
    output logic [3*DATA_W-1:0] queue_out,
    output logic [2:0]          queue_valid,
    output logic [PTR_W:0]      queue_count,
    output logic                queue_full,
    output logic                queue_push_drop,
    output logic                queue_pull_err
);

    // Handshake: queue_push and queue_pull_len are sampled every rising edge with no
    // ready signal. Priority is flush > pull > push; a push is judged against the
    // room left after the same-cycle legal pull, and rejected or illegal requests
    // are reported by registered one-cycle pulses one cycle later.

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr_s;
    logic [PTR_W-1:0]  ptr_e;
    logic [PTR_W:0]    count;
    logic              push_drop_q;
    logic              pull_err_q;

    logic [PTR_W:0]    pull_len_ext;
    logic              pull_ok;
    logic [PTR_W:0]    legal_len;
    logic [PTR_W:0]    count_after_pull;
    logic              push_acc;

    always_comb begin
        pull_len_ext     = (PTR_W+1)'(queue_pull_len);
        pull_ok          = (pull_len_ext <= count);
        legal_len        = pull_ok ? pull_len_ext : '0;
        count_after_pull = count - legal_len;
        push_acc         = queue_push && !queue_flush && (count_after_pull < DEPTH_C);
    end

    always_ff @(posedge queue_clk or negedge queue_reset_n) begin
        if (!queue_reset_n) begin
            ptr_s       <= '0;
            ptr_e       <= '0;
            count       <= '0;
            push_drop_q <= 1'b0;
            pull_err_q  <= 1'b0;
        end else if (queue_flush) begin
            // Flush swallows any same-cycle push or pull without reporting errors.
            ptr_s       <= '0;
            ptr_e       <= '0;
            count       <= '0;
            push_drop_q <= 1'b0;
            pull_err_q  <= 1'b0;
        end else begin
            if (pull_ok) begin
                ptr_s <= ptr_s + PTR_W'(queue_pull_len);
            end
            if (push_acc) begin
                ptr_e <= ptr_e + 1'b1;
            end
            count       <= count_after_pull + {{PTR_W{1'b0}}, push_acc};
            push_drop_q <= queue_push && !push_acc;
            pull_err_q  <= !pull_ok;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge queue_clk) begin
        if (push_acc) begin
            mem[ptr_e] <= queue_in;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_window
        logic [PTR_W-1:0] idx;
        assign idx                            = ptr_s + PTR_W'(i);
        assign queue_out[i*DATA_W +: DATA_W]  = mem[idx];
        assign queue_valid[i]                 = (count > (PTR_W+1)'(i));
    end

    assign queue_count     = count;
    assign queue_full      = (count == DEPTH_C);
    assign queue_push_drop = push_drop_q;
    assign queue_pull_err  = pull_err_q;

endmodule

// File: tb/tb_prefetch_byte_queue.sv
// Bench for prefetch_byte_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the byte stream.
module tb_prefetch_byte_queue;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = 4;

    logic                queue_clk;
    logic                queue_reset_n;
    logic                queue_flush;
    logic [DATA_W-1:0]   queue_in;
    logic                queue_push;
    logic [1:0]          queue_pull_len;
    logic [3*DATA_W-1:0] queue_out;
    logic [2:0]          queue_valid;
    logic [PTR_W:0]      queue_count;
    logic                queue_full;
    logic                queue_push_drop;
    logic                queue_pull_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic              exp_drop;
    logic              exp_err;

    prefetch_byte_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .queue_clk       (queue_clk),
        .queue_reset_n   (queue_reset_n),
        .queue_flush     (queue_flush),
        .queue_in        (queue_in),
        .queue_push      (queue_push),
        .queue_pull_len  (queue_pull_len),
        .queue_out       (queue_out),
        .queue_valid     (queue_valid),
        .queue_count     (queue_count),
        .queue_full      (queue_full),
        .queue_push_drop (queue_push_drop),
        .queue_pull_err  (queue_pull_err)
    );

    // clock / reset
    initial queue_clk = 1'b0;
    always #5 queue_clk = ~queue_clk;

    // model views of the decoder window
    function automatic logic [2:0] exp_valid();
        logic [2:0] v = '0;
        for (int i = 0; i < 3; i++) v[i] = (exp_q.size() > i);
        return v;
    endfunction

    function automatic logic [3*DATA_W-1:0] exp_window();
        logic [3*DATA_W-1:0] w = '0;
        for (int i = 0; i < 3; i++) if (exp_q.size() > i) w[i*DATA_W +: DATA_W] = exp_q[i];
        return w;
    endfunction

    function automatic logic [3*DATA_W-1:0] window_mask();
        logic [3*DATA_W-1:0] m = '0;
        for (int i = 0; i < 3; i++) if (exp_q.size() > i) m[i*DATA_W +: DATA_W] = '1;
        return m;
    endfunction

    // driver: applies one cycle of stimulus, advances the model, returns 1ns after the edge
    task automatic drive_cycle(input logic push, input logic [7:0] data,
                               input logic [1:0] pull, input logic flush);
        int room;
        @(negedge queue_clk);
        queue_push     = push;
        queue_in       = data;
        queue_pull_len = pull;
        queue_flush    = flush;
        if (flush) begin
            exp_q.delete();
            exp_drop = 1'b0;
            exp_err  = 1'b0;
        end else begin
            exp_err = (int'(pull) > exp_q.size());
            if (!exp_err) for (int i = 0; i < int'(pull); i++) void'(exp_q.pop_front());
            room     = DEPTH - exp_q.size();
            exp_drop = push && (room == 0);
            if (push && room > 0) exp_q.push_back(data);
        end
        @(posedge queue_clk);
        #1;
        queue_push     = 1'b0;
        queue_pull_len = 2'd0;
        queue_flush    = 1'b0;
    endtask

    task automatic test_reset();
        queue_reset_n  = 1'b0;
        queue_flush    = 1'b0;
        queue_push     = 1'b0;
        queue_in       = '0;
        queue_pull_len = 2'd0;
        exp_q.delete();
        exp_drop = 1'b0;
        exp_err  = 1'b0;
        repeat (3) @(posedge queue_clk);
        #1;
        n_checks++;
        if (queue_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", queue_count); end
        n_checks++;
        if (queue_valid !== 3'b000) begin n_fail++; $display("FAIL reset_valid: got %b expected 000", queue_valid); end
        n_checks++;
        if ({queue_full, queue_push_drop, queue_pull_err} !== 3'b000)
            begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {queue_full, queue_push_drop, queue_pull_err}); end
        @(negedge queue_clk);
        queue_reset_n = 1'b1;
    endtask

    task automatic test_basic();
        drive_cycle(1'b1, 8'hA9, 2'd0, 1'b0);
        drive_cycle(1'b1, 8'h05, 2'd0, 1'b0);
        drive_cycle(1'b1, 8'h8D, 2'd0, 1'b0);
        n_checks++;
        if (queue_count !== 5'd3) begin n_fail++; $display("FAIL basic_count: got %0d expected 3", queue_count); end
        n_checks++;
        if (queue_valid !== 3'b111) begin n_fail++; $display("FAIL basic_valid: got %b expected 111", queue_valid); end
        n_checks++;
        if (queue_out !== 24'h8D05A9) begin n_fail++; $display("FAIL basic_window: got %h expected 8d05a9", queue_out); end
        drive_cycle(1'b0, 8'h00, 2'd2, 1'b0);
        n_checks++;
        if (queue_count !== 5'd1) begin n_fail++; $display("FAIL pull2_count: got %0d expected 1", queue_count); end
        n_checks++;
        if (queue_out[7:0] !== 8'h8D) begin n_fail++; $display("FAIL pull2_slot0: got %h expected 8d", queue_out[7:0]); end
        n_checks++;
        if (queue_valid !== 3'b001) begin n_fail++; $display("FAIL pull2_valid: got %b expected 001", queue_valid); end
    endtask

    task automatic test_full_drop();
        drive_cycle(1'b0, 8'h00, 2'd0, 1'b1);
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 8'(i), 2'd0, 1'b0);
        n_checks++;
        if (queue_full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b expected 1", queue_full); end
        drive_cycle(1'b1, 8'hEE, 2'd0, 1'b0);
        n_checks++;
        if (queue_push_drop !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: got %b expected 1", queue_push_drop); end
        n_checks++;
        if (queue_count !== 5'd16) begin n_fail++; $display("FAIL drop_count: got %0d expected 16", queue_count); end
        drive_cycle(1'b0, 8'h00, 2'd0, 1'b0);
        n_checks++;
        if (queue_push_drop !== 1'b0) begin n_fail++; $display("FAIL drop_one_cycle: got %b expected 0", queue_push_drop); end
        n_checks++;
        if (queue_out[7:0] !== 8'h00) begin n_fail++; $display("FAIL drop_storage: got %h expected 00", queue_out[7:0]); end
    endtask

    task automatic test_full_push_pull();
        drive_cycle(1'b1, 8'h10, 2'd1, 1'b0);
        n_checks++;
        if (queue_count !== 5'd16) begin n_fail++; $display("FAIL fpp_count: got %0d expected 16", queue_count); end
        n_checks++;
        if (queue_out[7:0] !== 8'h01) begin n_fail++; $display("FAIL fpp_slot0: got %h expected 01", queue_out[7:0]); end
        n_checks++;
        if (queue_push_drop !== 1'b0) begin n_fail++; $display("FAIL fpp_drop: got %b expected 0", queue_push_drop); end
        // drain to confirm 0x10 landed at the tail
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 8'h00, 2'd3, 1'b0);
        n_checks++;
        if (queue_out[7:0] !== 8'h10) begin n_fail++; $display("FAIL fpp_tail: got %h expected 10", queue_out[7:0]); end
    endtask

    task automatic test_wrap();
        int next_byte = 8'h20;
        int guard = 0;
        logic [1:0] pl;
        while ((next_byte <= 8'h33 || exp_q.size() > 0) && guard < 400) begin
            guard++;
            pl = 2'($urandom_range(0, 3));
            if (int'(pl) > exp_q.size()) pl = 2'(exp_q.size());
            if (next_byte <= 8'h33 && $urandom_range(0, 3) != 0) begin
                drive_cycle(1'b1, 8'(next_byte), pl, 1'b0);
                next_byte++;
            end else begin
                drive_cycle(1'b0, 8'h00, pl, 1'b0);
            end
            n_checks++;
            if (queue_count !== (PTR_W+1)'(exp_q.size()))
                begin n_fail++; $display("FAIL wrap_count: got %0d expected %0d", queue_count, exp_q.size()); end
            n_checks++;
            if ((queue_out & window_mask()) !== exp_window())
                begin n_fail++; $display("FAIL wrap_window: got %h expected %h", queue_out & window_mask(), exp_window()); end
        end
        n_checks++;
        if (guard >= 400) begin n_fail++; $display("FAIL wrap_budget: got %0d cycles expected under 400", guard); end
    endtask

    task automatic test_pull_err();
        drive_cycle(1'b0, 8'h00, 2'd0, 1'b1);
        drive_cycle(1'b1, 8'h77, 2'd1, 1'b0);
        n_checks++;
        if (queue_pull_err !== 1'b1) begin n_fail++; $display("FAIL empty_pull_err: got %b expected 1", queue_pull_err); end
        n_checks++;
        if (queue_count !== 5'd1) begin n_fail++; $display("FAIL empty_pull_count: got %0d expected 1", queue_count); end
        drive_cycle(1'b0, 8'h00, 2'd3, 1'b0);
        n_checks++;
        if (queue_pull_err !== 1'b1) begin n_fail++; $display("FAIL pull3_err: got %b expected 1", queue_pull_err); end
        n_checks++;
        if (queue_count !== 5'd1) begin n_fail++; $display("FAIL pull3_count: got %0d expected 1", queue_count); end
        drive_cycle(1'b0, 8'h00, 2'd1, 1'b0);
        n_checks++;
        if (queue_pull_err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b expected 0", queue_pull_err); end
        n_checks++;
        if (queue_count !== 5'd0) begin n_fail++; $display("FAIL after_err_pull: got %0d expected 0", queue_count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'($urandom), 2'd0, 1'b0);
        drive_cycle(1'b1, 8'h55, 2'd3, 1'b1);
        n_checks++;
        if (queue_count !== 5'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", queue_count); end
        n_checks++;
        if (queue_valid !== 3'b000) begin n_fail++; $display("FAIL flush_valid: got %b expected 000", queue_valid); end
        n_checks++;
        if ({queue_push_drop, queue_pull_err} !== 2'b00)
            begin n_fail++; $display("FAIL flush_pulses: got %b expected 00", {queue_push_drop, queue_pull_err}); end
    endtask

    task automatic test_random();
        logic       push;
        logic [1:0] pl;
        logic       fl;
        for (int c = 0; c < 300; c++) begin
            push = ($urandom_range(0, 3) != 0);
            pl   = 2'($urandom_range(0, 3));
            fl   = ($urandom_range(0, 40) == 0);
            drive_cycle(push, 8'($urandom), pl, fl);
            n_checks++;
            if (queue_count !== (PTR_W+1)'(exp_q.size()) || queue_full !== (exp_q.size() == DEPTH))
                begin n_fail++; $display("FAIL rand_count: got %0d/%b expected %0d", queue_count, queue_full, exp_q.size()); end
            n_checks++;
            if (queue_valid !== exp_valid() || (queue_out & window_mask()) !== exp_window())
                begin n_fail++; $display("FAIL rand_window: got %b %h expected %b %h", queue_valid, queue_out & window_mask(), exp_valid(), exp_window()); end
            n_checks++;
            if (queue_push_drop !== exp_drop || queue_pull_err !== exp_err)
                begin n_fail++; $display("FAIL rand_pulses: got %b%b expected %b%b", queue_push_drop, queue_pull_err, exp_drop, exp_err); end
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b0, 8'h00, 2'd0, 1'b1);
        for (int i = 0; i < 7; i++) drive_cycle(1'b1, 8'(8'h40 + i), 2'd0, 1'b0);
        n_checks++;
        if (queue_count !== 5'd7) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected 7", queue_count); end
        #1;
        queue_reset_n = 1'b0;
        exp_q.delete();
        #1;
        n_checks++;
        if (queue_count !== 5'd0) begin n_fail++; $display("FAIL async_count: got %0d expected 0", queue_count); end
        n_checks++;
        if (queue_full !== 1'b0 || queue_valid !== 3'b000)
            begin n_fail++; $display("FAIL async_flags: got %b %b expected 0 000", queue_full, queue_valid); end
        @(negedge queue_clk);
        queue_reset_n = 1'b1;
        drive_cycle(1'b1, 8'hC3, 2'd0, 1'b0);
        n_checks++;
        if (queue_count !== 5'd1 || queue_out[7:0] !== 8'hC3)
            begin n_fail++; $display("FAIL post_reset_push: got %0d %h expected 1 c3", queue_count, queue_out[7:0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_drop();
        test_full_push_pull();
        drive_cycle(1'b0, 8'h00, 2'd0, 1'b1);
        test_wrap();
        test_pull_err();
        test_flush();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no completion expected finish before 500000ns");
        $fatal(1, "timeout");
    end

endmodule
